// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
//
// Drives NUM_CH active-high channel resets from one synchronous master reset.
// After the master reset (or an accepted re-reset request) the affected
// channels stay in reset for HOLD_CYCLES edges and are then released one at a
// time, lowest index first, STAGGER_CYCLES edges apart.  STAGGER_CYCLES = 0
// releases every affected channel on the same edge.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high master reset (all channels)
//   trig       in   re-reset request, sampled every cycle
//   trig_mask  in   channels affected by trig (sampled with trig)
//   ch_reset   out  per-channel active-high reset
//   busy       out  a hold/release sequence is in progress
//   rel_done   out  one-cycle pulse on the edge that releases the last channel
//   dropped    out  one-cycle pulse when a trig arrives while busy
//   trig_count out  number of accepted trigs, saturating at all-ones
//
// All outputs come straight from flops; there is no input-to-output
// combinational path.
// -----------------------------------------------------------------------------
module reset_sequencer #(
  parameter int NUM_CH         = 4,
  parameter int HOLD_CYCLES    = 8,
  parameter int STAGGER_CYCLES = 2,
  parameter int CNT_W          = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trig,
  input  logic [NUM_CH-1:0] trig_mask,
  output logic [NUM_CH-1:0] ch_reset,
  output logic              busy,
  output logic              rel_done,
  output logic              dropped,
  output logic [CNT_W-1:0]  trig_count
);

  localparam logic [1:0] ST_HOLD    = 2'd0;
  localparam logic [1:0] ST_RELEASE = 2'd1;
  localparam logic [1:0] ST_IDLE    = 2'd2;

  // Timer must reach max(HOLD_CYCLES, STAGGER_CYCLES) - 1.
  localparam int TMAX = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int TW   = (TMAX < 1) ? 1 : $clog2(TMAX + 1);

  localparam logic [NUM_CH-1:0] ONE_CH   = NUM_CH'(1);
  localparam logic [TW-1:0]     ONE_T    = TW'(1);
  localparam logic [CNT_W-1:0]  ONE_CNT  = CNT_W'(1);
  localparam logic [TW-1:0]     HOLD_END = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0]     STAG_END = TW'(STAGGER_CYCLES - 1);

  logic [1:0]        state_q,    state_d;
  logic [NUM_CH-1:0] pend_q,     pend_d;      // channels still waiting for release
  logic [TW-1:0]     tmr_q,      tmr_d;
  logic [NUM_CH-1:0] ch_reset_q, ch_reset_d;
  logic              busy_q,     busy_d;
  logic              rel_done_q, rel_done_d;
  logic              dropped_q,  dropped_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;

  logic [NUM_CH-1:0] lowest_s;
  logic [NUM_CH-1:0] rel_set_s;
  logic [NUM_CH-1:0] left_s;
  logic [CNT_W-1:0]  cnt_inc_s;

  // Lowest set bit of the pending mask (x & -x acts as the priority encoder),
  // the set of channels released on a release edge, and what remains after it.
  always_comb begin
    lowest_s = pend_q & (~pend_q + ONE_CH);
    if (STAGGER_CYCLES == 0) begin
      rel_set_s = pend_q;
    end else begin
      rel_set_s = lowest_s;
    end
    left_s = pend_q & ~rel_set_s;
  end

  // Saturating increment for the accepted-trig counter.
  always_comb begin
    if (&cnt_q) begin
      cnt_inc_s = cnt_q;
    end else begin
      cnt_inc_s = cnt_q + ONE_CNT;
    end
  end

  // Next-state logic for the hold / release / idle sequencer.
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    tmr_d      = tmr_q;
    ch_reset_d = ch_reset_q;
    busy_d     = busy_q;
    rel_done_d = 1'b0;
    cnt_d      = cnt_q;

    // A request while a sequence is running is rejected and flagged.
    if (trig && busy_q) begin
      dropped_d = 1'b1;
    end else begin
      dropped_d = 1'b0;
    end

    case (state_q)
      ST_HOLD, ST_RELEASE: begin
        if ((state_q == ST_HOLD && tmr_q == HOLD_END) ||
            (state_q == ST_RELEASE && tmr_q == STAG_END)) begin
          ch_reset_d = ch_reset_q & ~rel_set_s;
          pend_d     = left_s;
          tmr_d      = '0;
          if (left_s == '0) begin
            state_d    = ST_IDLE;
            busy_d     = 1'b0;
            rel_done_d = 1'b1;
          end else begin
            state_d    = ST_RELEASE;
          end
        end else begin
          tmr_d = tmr_q + ONE_T;
        end
      end
      ST_IDLE: begin
        // An empty mask is not a request at all.
        if (trig && (trig_mask != '0)) begin
          ch_reset_d = ch_reset_q | trig_mask;
          pend_d     = trig_mask;
          tmr_d      = '0;
          busy_d     = 1'b1;
          cnt_d      = cnt_inc_s;
          state_d    = ST_HOLD;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      default: begin
        // Unreachable encoding: fall back to a full all-channel sequence.
        state_d    = ST_HOLD;
        pend_d     = '1;
        tmr_d      = '0;
        ch_reset_d = '1;
        busy_d     = 1'b1;
      end
    endcase
  end

  // State and output registers; master reset restarts a full sequence.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_HOLD;
      pend_q     <= '1;
      tmr_q      <= '0;
      ch_reset_q <= '1;
      busy_q     <= 1'b1;
      rel_done_q <= 1'b0;
      dropped_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      tmr_q      <= tmr_d;
      ch_reset_q <= ch_reset_d;
      busy_q     <= busy_d;
      rel_done_q <= rel_done_d;
      dropped_q  <= dropped_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ch_reset   = ch_reset_q;
  assign busy       = busy_q;
  assign rel_done   = rel_done_q;
  assign dropped    = dropped_q;
  assign trig_count = cnt_q;

endmodule
